// File: rtl/puck_engine_pkg.sv
// rtl/puck_engine_pkg.sv - shared field geometry, serve origin and FSM encoding for the puck engine
package puck_engine_pkg;

  // Playfield columns; paddle columns are X_MIN and X_MAX, the puck bounces one column inside them
  localparam logic [2:0] X_MIN       = 3'd0;
  localparam logic [2:0] X_MAX       = 3'd7;
  localparam logic [2:0] LEFT_HIT_X  = 3'd1;
  localparam logic [2:0] RIGHT_HIT_X = 3'd6;

  // Playfield rows (walls)
  localparam logic [2:0] Y_MIN = 3'd0;
  localparam logic [2:0] Y_MAX = 3'd7;

  // Serve origin
  localparam logic [2:0] SERVE_X = 3'd3;
  localparam logic [2:0] SERVE_Y = 3'd3;

  // Paddle position the paddle controller comes out of reset with
  localparam logic [7:0] PADDLE_RESET_MASK = 8'b0011_1000;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GOAL  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // One-hot row select driven to the matrix scan driver
  function automatic logic [7:0] row_onehot(input logic [2:0] y);
    return 8'b0000_0001 << y;
  endfunction

endpackage

// File: rtl/puck_engine_game_tick_gen.sv
// rtl/puck_engine_game_tick_gen.sv - divides clk down to a one-cycle game tick
module game_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..TICK_DIV-1 while enabled; tick fires on the last count and the counter wraps
  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == CW'(TICK_DIV - 1));
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/puck_engine.sv
// rtl/puck_engine.sv - puck motion, wall/paddle collision and scoring for the 8x8 air-hockey game
module puck_engine
  import puck_engine_pkg::*;
#(
  parameter int TICK_DIV    = 25_000_000,
  parameter int SERVE_TICKS = 4,
  parameter int GOAL_TICKS  = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] leftpos,
  input  logic [7:0] rightpos,
  output logic [2:0] puck_x,
  output logic [2:0] puck_y,
  output logic [7:0] puck_row,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       goal_l,
  output logic       goal_r,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  game_state_e state_q, state_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  row_q, row_d;
  logic        dx_pos_q, dx_pos_d;      // 1: moving right
  logic        dy_pos_q, dy_pos_d;      // 1: moving toward row 7
  logic        serve_right_q, serve_right_d;
  logic [7:0]  hold_q, hold_d;          // ticks spent in SERVE / GOAL
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic        goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic        over_q, over_d, winner_q, winner_d;
  logic        tick;
  logic [2:0]  ny;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_OVER),
    .tick  (tick)
  );

  // Next-state: serve/goal hold timers, wall reflect, then paddle hit/miss on the reflected row
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    dx_pos_d      = dx_pos_q;
    dy_pos_d      = dy_pos_q;
    serve_right_d = serve_right_q;
    hold_d        = hold_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    goal_l_d      = 1'b0;
    goal_r_d      = 1'b0;
    over_d        = over_q;
    winner_d      = winner_q;

    if (y_q == Y_MAX && dy_pos_q) begin
      ny = y_q - 3'd1;
    end else if (y_q == Y_MIN && !dy_pos_q) begin
      ny = y_q + 3'd1;
    end else begin
      ny = dy_pos_q ? y_q + 3'd1 : y_q - 3'd1;
    end

    if (tick) begin
      case (state_q)
        ST_SERVE: begin
          if (hold_q == 8'(SERVE_TICKS - 1)) begin
            hold_d   = '0;
            state_d  = ST_PLAY;
            dx_pos_d = serve_right_q;
            dy_pos_d = 1'b1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        ST_PLAY: begin
          if ((y_q == Y_MAX && dy_pos_q) || (y_q == Y_MIN && !dy_pos_q)) begin
            dy_pos_d = !dy_pos_q;
          end
          y_d = ny;
          if (x_q == LEFT_HIT_X && !dx_pos_q) begin
            if (leftpos[ny]) begin
              dx_pos_d = 1'b1;
            end else begin
              x_d           = X_MIN;
              score_r_d     = (score_r_q == WIN) ? score_r_q : score_r_q + 4'd1;
              goal_r_d      = 1'b1;
              serve_right_d = 1'b0;
              hold_d        = '0;
              state_d       = ST_GOAL;
            end
          end else if (x_q == RIGHT_HIT_X && dx_pos_q) begin
            if (rightpos[ny]) begin
              dx_pos_d = 1'b0;
            end else begin
              x_d           = X_MAX;
              score_l_d     = (score_l_q == WIN) ? score_l_q : score_l_q + 4'd1;
              goal_l_d      = 1'b1;
              serve_right_d = 1'b1;
              hold_d        = '0;
              state_d       = ST_GOAL;
            end
          end else begin
            x_d = dx_pos_q ? x_q + 3'd1 : x_q - 3'd1;
          end
        end
        ST_GOAL: begin
          if (hold_q == 8'(GOAL_TICKS - 1)) begin
            hold_d = '0;
            if (score_l_q == WIN || score_r_q == WIN) begin
              state_d  = ST_OVER;
              over_d   = 1'b1;
              winner_d = (score_r_q == WIN);
            end else begin
              state_d = ST_SERVE;
              x_d     = SERVE_X;
              y_d     = SERVE_Y;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    row_d = row_onehot(y_d);
  end

  // Game FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_SERVE;
      x_q           <= SERVE_X;
      y_q           <= SERVE_Y;
      row_q         <= row_onehot(SERVE_Y);
      dx_pos_q      <= 1'b1;
      dy_pos_q      <= 1'b1;
      serve_right_q <= 1'b1;
      hold_q        <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      goal_l_q      <= 1'b0;
      goal_r_q      <= 1'b0;
      over_q        <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      row_q         <= row_d;
      dx_pos_q      <= dx_pos_d;
      dy_pos_q      <= dy_pos_d;
      serve_right_q <= serve_right_d;
      hold_q        <= hold_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      goal_l_q      <= goal_l_d;
      goal_r_q      <= goal_r_d;
      over_q        <= over_d;
      winner_q      <= winner_d;
    end
  end

  assign puck_x    = x_q;
  assign puck_y    = y_q;
  assign puck_row  = row_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign goal_l    = goal_l_q;
  assign goal_r    = goal_r_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_puck_engine.sv
// tb/tb_puck_engine.sv - directed checks of serve, bounces, goals, game over and reset
module tb_puck_engine;
  import puck_engine_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] leftpos, rightpos;
  logic [2:0] puck_x, puck_y;
  logic [7:0] puck_row;
  logic [3:0] score_l, score_r;
  logic       goal_l, goal_r, game_over, winner;

  int n_assert = 0;
  int n_fail   = 0;

  puck_engine #(
    .TICK_DIV(4), .SERVE_TICKS(2), .GOAL_TICKS(2), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .reset(reset), .leftpos(leftpos), .rightpos(rightpos),
    .puck_x(puck_x), .puck_y(puck_y), .puck_row(puck_row),
    .score_l(score_l), .score_r(score_r), .goal_l(goal_l), .goal_r(goal_r),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [2:0] ex, input logic [2:0] ey);
    logic [7:0] er;
    er = 8'b0000_0001 << ey;
    chk({tag, ".x"}, 16'(puck_x), 16'(ex));
    chk({tag, ".y"}, 16'(puck_y), 16'(ey));
    chk({tag, ".row"}, 16'(puck_row), 16'(er));
  endtask

  task automatic chk_game(input string tag, input logic [3:0] sl, input logic [3:0] sr,
                          input logic gl, input logic gr, input logic ov, input logic wn);
    chk({tag, ".score_l"}, 16'(score_l), 16'(sl));
    chk({tag, ".score_r"}, 16'(score_r), 16'(sr));
    chk({tag, ".goal_l"}, 16'(goal_l), 16'(gl));
    chk({tag, ".goal_r"}, 16'(goal_r), 16'(gr));
    chk({tag, ".game_over"}, 16'(game_over), 16'(ov));
    chk({tag, ".winner"}, 16'(winner), 16'(wn));
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    clks(4 * n);
  endtask

  initial begin
    leftpos  = 8'hFF;
    rightpos = 8'hFF;

    // Reset held 3 clks
    reset = 1'b0;
    clks(3);
    reset = 1'b1;
    chk_pos("reset", 3'd3, 3'd3);
    chk_game("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Serve hold, first move, rally with both paddles solid
    ticks(2);  chk_pos("serve_hold", 3'd3, 3'd3);
    ticks(1);  chk_pos("first_move", 3'd4, 3'd4);
    ticks(3);  chk_pos("right_hit", 3'd6, 3'd7);
    ticks(1);  chk_pos("top_reflect", 3'd5, 3'd6);
    chk_game("top_reflect", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(5);  chk_pos("left_hit", 3'd1, 3'd1);
    ticks(2);  chk_pos("bottom_reflect", 3'd3, 3'd1);
    ticks(69); chk_pos("corner_setup", 3'd1, 3'd0);

    // Corner: y=0 moving down at x=1 moving left; row 1 is tested, not row 0
    leftpos = 8'b0000_0001;
    ticks(1);  chk_pos("corner_miss", 3'd0, 3'd1);
    chk_game("corner_miss", 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    clks(1);   chk("goal_r_pulse_end", 16'(goal_r), 16'd0);
    clks(3);   chk_pos("goal_hold", 3'd0, 3'd1);
    ticks(1);  chk_pos("reserve", 3'd3, 3'd3);

    // Serve toward the left, left paddle hit on row 6
    leftpos = 8'b0111_0000;
    ticks(3);  chk_pos("serve_left", 3'd2, 3'd4);
    ticks(2);  chk_pos("left_hit2", 3'd1, 3'd6);
    chk_game("left_hit2", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty right paddle: left player scores
    rightpos = 8'h00;
    ticks(6);  chk_pos("right_miss", 3'd7, 3'd2);
    chk_game("right_miss", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    clks(1);   chk("goal_l_pulse_end", 16'(goal_l), 16'd0);
    clks(3);

    // Serve right, empty left paddle: right reaches winning score
    rightpos = 8'hFF;
    leftpos  = 8'h00;
    ticks(13); chk_pos("final_miss", 3'd0, 3'd1);
    chk_game("final_miss", 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);  chk("pre_over", 16'(game_over), 16'd0);
    ticks(1);  chk_pos("over", 3'd0, 3'd1);
    chk_game("over", 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    leftpos  = 8'hFF;
    clks(20);  chk_pos("over_frozen", 3'd0, 3'd1);
    chk_game("over_frozen", 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset out of OVER
    reset = 1'b0;
    clks(3);
    reset = 1'b1;
    chk_pos("reset2", 3'd3, 3'd3);
    chk_game("reset2", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Score once, then a one-clk reset mid-tick during PLAY
    leftpos  = PADDLE_RESET_MASK;
    rightpos = 8'h00;
    ticks(6);  chk_pos("miss_r", 3'd7, 3'd7);
    chk_game("miss_r", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);  chk_pos("play_again", 3'd4, 3'd4);
    clks(2);
    reset = 1'b0;
    clks(1);
    reset = 1'b1;
    chk_pos("mid_reset", 3'd3, 3'd3);
    chk_game("mid_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);  chk_pos("mid_reset_serve", 3'd3, 3'd3);
    clks(3);   chk_pos("mid_reset_pre_move", 3'd3, 3'd3);
    clks(1);   chk_pos("mid_reset_move", 3'd4, 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
